// File: rtl/fft_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the mic / FFT / VGA side.
// The scheduler uses the master modport; the surrounding logic uses slave.
interface fft_frame_scheduler_if #(
    parameter int OVF_WIDTH = 8
);
    logic                 frame_ready;
    logic                 fft_done;
    logic                 vga_busy;
    logic                 mic_bank;
    logic                 fft_bank;
    logic                 fft_start;
    logic                 result_valid;
    logic                 busy;
    logic [OVF_WIDTH-1:0] overrun_count;
    logic                 timeout_flag;

    modport master (
        input  frame_ready, fft_done, vga_busy,
        output mic_bank, fft_bank, fft_start, result_valid, busy,
               overrun_count, timeout_flag
    );

    modport slave (
        output frame_ready, fft_done, vga_busy,
        input  mic_bank, fft_bank, fft_start, result_valid, busy,
               overrun_count, timeout_flag
    );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Ping-pong bank sequencer for mic capture -> FFT -> VGA, with frame decimation,
// RUN watchdog and overrun counting. Optional one-deep pending frame: FFT_SCHED_PENDING_EN.
module fft_frame_scheduler #(
    parameter int ADDR_WIDTH     = 9,
    parameter int FRAME_SKIP     = 0,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int OVF_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_frame_scheduler_if.master bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_PUBLISH = 2'd3;

    localparam int unsigned TMR_W  = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SKIP_W = ($clog2(FRAME_SKIP + 1) > 0) ? $clog2(FRAME_SKIP + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP);

    if (ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1 || FRAME_SKIP < 0 || OVF_WIDTH < 1) begin : g_cfg_check
        $error("fft_frame_scheduler: invalid parameter set");
    end

    logic [1:0]           state;
    logic                 mic_bank_q;
    logic                 fft_bank_q;
    logic                 fft_start_q;
    logic                 result_valid_q;
    logic                 timeout_q;
    logic [SKIP_W-1:0]    skip_cnt;
    logic [TMR_W-1:0]     timer;
    logic [OVF_WIDTH-1:0] ovf_cnt;
    logic                 frame_evt;
    logic                 overrun_evt;

`ifdef FFT_SCHED_PENDING_EN
    logic pending;

    // A parked frame is replayed as a frame_ready on the first IDLE cycle;
    // a real pulse landing in that same cycle merges with it.
    always_comb begin
        frame_evt   = bus.frame_ready | pending;
        overrun_evt = (state != S_IDLE) && bus.frame_ready && pending;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pending <= 1'b0;
        else if (state == S_IDLE)
            pending <= 1'b0;
        else if (bus.frame_ready)
            pending <= 1'b1;
    end
`else
    always_comb begin
        frame_evt   = bus.frame_ready;
        overrun_evt = (state != S_IDLE) && bus.frame_ready;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mic_bank_q     <= 1'b0;
            fft_bank_q     <= 1'b1;
            fft_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            skip_cnt       <= '0;
            timer          <= '0;
            ovf_cnt        <= '0;
        end else begin
            fft_start_q    <= 1'b0;
            result_valid_q <= 1'b0;

            if (overrun_evt && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (frame_evt) begin
                        if (skip_cnt != SKIP_LAST) begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end else begin
                            skip_cnt    <= '0;
                            fft_bank_q  <= mic_bank_q;
                            mic_bank_q  <= ~mic_bank_q;
                            fft_start_q <= 1'b1;
                            state       <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    timer <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (bus.fft_done) begin
                        state <= S_PUBLISH;
                    end else if (timer == TMR_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_PUBLISH: begin
                    if (!bus.vga_busy) begin
                        result_valid_q <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mic_bank      = mic_bank_q;
    assign bus.fft_bank      = fft_bank_q;
    assign bus.fft_start     = fft_start_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.busy          = (state != S_IDLE);
    assign bus.overrun_count = ovf_cnt;
    assign bus.timeout_flag  = timeout_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_fft_frame_scheduler;

    localparam int ADDR_WIDTH     = 9;
    localparam int FRAME_SKIP     = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int OVF_WIDTH      = 2;
    localparam int OVF_MAX        = (1 << OVF_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_frame_scheduler_if #(.OVF_WIDTH(OVF_WIDTH)) bus ();

    fft_frame_scheduler #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .FRAME_SKIP    (FRAME_SKIP),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .OVF_WIDTH     (OVF_WIDTH)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: where the frame is in its life, not how the RTL encodes it.
    typedef enum int {M_IDLE, M_ARM, M_RUN, M_PUBLISH} phase_t;
    phase_t m_phase;
    bit     m_mic, m_start, m_rv, m_to, m_pend;
    int     m_ovf, m_frames, m_elapsed;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic busy_frame();
`ifdef FFT_SCHED_PENDING_EN
        if (!m_pend) begin
            m_pend = 1'b1;
            return;
        end
`endif
        m_ovf = (m_ovf < OVF_MAX) ? m_ovf + 1 : OVF_MAX;
    endtask

    task automatic model_update(input bit fr, input bit done, input bit vb, input bit rs);
        bit take;
        if (rs) begin
            m_phase = M_IDLE; m_mic = 0; m_start = 0; m_rv = 0; m_to = 0;
            m_pend = 0; m_ovf = 0; m_frames = 0; m_elapsed = 0;
            return;
        end
        m_start = 0;
        m_rv    = 0;
        if (m_phase != M_IDLE && fr) busy_frame();
        case (m_phase)
            M_IDLE: begin
                take   = fr || m_pend;
                m_pend = 0;
                if (take) begin
                    m_frames++;
                    if (m_frames > FRAME_SKIP) begin
                        m_frames = 0;
                        m_mic    = !m_mic;
                        m_start  = 1;
                        m_phase  = M_ARM;
                    end
                end
            end
            M_ARM: begin
                m_elapsed = 0;
                m_phase   = M_RUN;
            end
            M_RUN: begin
                if (done) begin
                    m_phase = M_PUBLISH;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == TIMEOUT_CYCLES) begin
                        m_to    = 1;
                        m_phase = M_IDLE;
                    end
                end
            end
            M_PUBLISH: begin
                if (!vb) begin
                    m_rv    = 1;
                    m_phase = M_IDLE;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic step(input bit fr, input bit done, input bit vb, input bit rs);
        @(negedge clk);
        rst             = rs;
        bus.frame_ready = fr;
        bus.fft_done    = done;
        bus.vga_busy    = vb;
        model_update(fr, done, vb, rs);
        @(posedge clk);
        #1;
        check("mic_bank",      bus.mic_bank,      m_mic);
        check("fft_bank",      bus.fft_bank,      !m_mic);
        check("fft_start",     bus.fft_start,     m_start);
        check("result_valid",  bus.result_valid,  m_rv);
        check("busy",          bus.busy,          m_phase != M_IDLE);
        check("overrun_count", bus.overrun_count, m_ovf);
        check("timeout_flag",  bus.timeout_flag,  m_to);
    endtask

    task automatic idle(input int n, input bit vb);
        for (int i = 0; i < n; i++) step(0, 0, vb, 0);
    endtask

    // Pulse frame_ready (with gaps) until the model says a frame was accepted.
    task automatic accept_frame();
        for (int i = 0; i < 2 * (FRAME_SKIP + 2) && !m_start; i++) begin
            step(1, 0, 0, 0);
            if (!m_start) step(0, 0, 0, 0);
        end
    endtask

    initial begin
        bus.frame_ready = 1'b0;
        bus.fft_done    = 1'b0;
        bus.vga_busy    = 1'b0;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Basic frame: accept, run, done, publish.
        accept_frame();
        idle(1, 0);
        idle(10, 0);
        step(0, 1, 0, 0);
        idle(3, 0);

        // VGA busy holds PUBLISH for 40 cycles.
        accept_frame();
        idle(6, 0);
        step(0, 1, 1, 0);
        idle(40, 1);
        idle(3, 0);

        // Watchdog expiry, then done coinciding with the expiry cycle.
        accept_frame();
        idle(1 + TIMEOUT_CYCLES + 2, 0);
        step(0, 0, 0, 1);
        accept_frame();
        idle(1 + TIMEOUT_CYCLES - 1, 0);
        step(0, 1, 0, 0);
        idle(3, 0);

        // Overruns during RUN saturate the counter.
        accept_frame();
        idle(1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        step(0, 1, 0, 0);
        idle(6, 0);

        // Reset pulse mid-RUN.
        accept_frame();
        idle(4, 0);
        step(0, 0, 0, 1);
        idle(4, 0);

        // Randomized traffic with occasional resets.
        begin
            bit vb = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(19, 0) == 0) vb = !vb;
                step($urandom_range(7, 0) == 0,
                     $urandom_range(9, 0) == 0,
                     vb,
                     $urandom_range(399, 0) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
